// File: rtl/delay_var_sv.sv
// Run-time programmable delay line for valid-tagged samples (circular buffer, clock enable).
// Optional `DELAY_VAR_CLAMP_FLAG_EN adds a registered delay_err flag for out-of-range requests.
module delay_var_sv #(
    parameter int unsigned         num_bits      = 16,
    parameter int unsigned         max_cycles    = 16,
    parameter int unsigned         default_delay = 1,
    parameter logic [num_bits-1:0] initial_value = '0
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              enable,
    input  logic [$clog2(max_cycles+1)-1:0]   delay,
    input  logic                              in_valid,
    input  logic [num_bits-1:0]               in_data,
    output logic                              out_valid,
    output logic [num_bits-1:0]               out_data,
    output logic                              busy
`ifdef DELAY_VAR_CLAMP_FLAG_EN
    ,
    output logic                              delay_err
`endif
);

    localparam int unsigned AW = (max_cycles > 1) ? $clog2(max_cycles) : 1;
    localparam int unsigned DW = $clog2(max_cycles + 1);

    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] FLUSH = 1'b1;

    logic [num_bits-1:0]   mem_data [max_cycles];
    logic [max_cycles-1:0] mem_valid;
    logic [AW-1:0]         wp;
    logic [DW-1:0]         delay_q;
    logic [DW-1:0]         fcnt;
    logic [0:0]            state;
    logic                  out_valid_q;
    logic [num_bits-1:0]   out_data_q;

    logic [DW-1:0] dc;
    logic [DW-1:0] d;
    logic [DW-1:0] d_m1;
    logic          change;
    logic [AW:0]   rd_sum;
    logic [AW-1:0] rd_idx;
    logic [AW-1:0] wp_next;

    always_comb begin
        dc      = (delay > DW'(max_cycles)) ? DW'(max_cycles) : delay;
        d       = (delay_q > DW'(max_cycles)) ? DW'(max_cycles) : delay_q;
        d_m1    = d - DW'(1);
        change  = (dc != delay_q);
        // Slot written d-1 enabled edges ago; sum stays below 2*max_cycles so one subtract wraps.
        rd_sum  = {1'b0, wp} + (AW+1)'(max_cycles) - (AW+1)'(d_m1);
        rd_idx  = (rd_sum >= (AW+1)'(max_cycles)) ? AW'(rd_sum - (AW+1)'(max_cycles))
                                                  : AW'(rd_sum);
        wp_next = (wp == AW'(max_cycles - 1)) ? '0 : wp + AW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(max_cycles); i++) begin
                mem_data[i] <= initial_value;
            end
            mem_valid   <= '0;
            wp          <= '0;
            delay_q     <= DW'(default_delay);
            fcnt        <= '0;
            state       <= RUN;
            out_valid_q <= 1'b0;
            out_data_q  <= initial_value;
        end else if (enable) begin
            wp <= wp_next;
            if (change) begin
                // Drop everything already in flight so no misaligned sample is flagged valid.
                delay_q     <= dc;
                mem_valid   <= '0;
                out_valid_q <= 1'b0;
                state       <= FLUSH;
                fcnt        <= dc;
            end else begin
                mem_data[wp]  <= in_data;
                mem_valid[wp] <= in_valid;
                if (d == DW'(1)) begin
                    out_valid_q <= in_valid;
                    out_data_q  <= in_data;
                end else if (d >= DW'(2)) begin
                    out_valid_q <= mem_valid[rd_idx];
                    out_data_q  <= mem_data[rd_idx];
                end
                if (state == FLUSH) begin
                    if (fcnt <= DW'(1)) begin
                        state <= RUN;
                        fcnt  <= '0;
                    end else begin
                        fcnt <= fcnt - DW'(1);
                    end
                end
            end
        end
    end

`ifdef DELAY_VAR_CLAMP_FLAG_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            delay_err <= 1'b0;
        end else begin
            delay_err <= (delay > DW'(max_cycles));
        end
    end
`endif

    always_comb begin
        busy      = (state == FLUSH);
        out_valid = (d == '0) ? in_valid : out_valid_q;
        out_data  = (d == '0) ? in_data : out_data_q;
    end

endmodule
